// File: rtl/vector_tile_buffer.sv
// vector_tile_buffer: multi-slot tile store between the vector DRAM loader
// and the compute datapath. Tiles are captured per tile_in pulse into one
// of NUM_BUFS buffers; the tile count is committed when the loader signals
// load_done. A buffer is streamed back out over a valid/ready handshake.
//
// Build option: define VBUF_PAD_READ_EN to make reads return the requested
// length (clamped to MAX_TILES), with tiles past the stored count as zero.
module vector_tile_buffer #(
    parameter int TILE_WIDTH = 256,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BUFS   = 4,
    parameter int MAX_TILES  = 32,
    localparam int ELEM      = TILE_WIDTH / DATA_WIDTH,
    localparam int BW        = (NUM_BUFS > 1) ? $clog2(NUM_BUFS) : 1,
    localparam int CW        = $clog2(MAX_TILES + 1)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_start,
    input  logic [BW-1:0]         wr_buf_id,
    input  logic                  tile_in,
    input  logic [DATA_WIDTH-1:0] tile_data [ELEM],
    input  logic                  load_done,
    output logic                  wr_busy,
    output logic                  wr_done,
    output logic                  wr_overflow,
    input  logic                  rd_start,
    input  logic [BW-1:0]         rd_buf_id,
    input  logic [CW-1:0]         rd_num_tiles,
    output logic [DATA_WIDTH-1:0] rd_data [ELEM],
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic                  rd_last,
    output logic                  rd_busy,
    output logic                  rd_done,
    output logic                  rd_err
);

    localparam int DEPTH = NUM_BUFS * MAX_TILES;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {W_IDLE, W_FILL, W_COMMIT} w_state_t;
    typedef enum logic       {R_IDLE, R_STREAM}         r_state_t;

    // Tile storage, flattened as buffer-major slots; deliberately not reset.
    logic [TILE_WIDTH-1:0] mem_reg [DEPTH];
    logic [CW-1:0]         count_reg [NUM_BUFS];

    logic [TILE_WIDTH-1:0] tile_packed;
    logic [TILE_WIDTH-1:0] rd_data_reg;

    // Write side state
    w_state_t      w_state_reg, w_state_next;
    logic [BW-1:0] wr_id_reg, wr_id_next;
    logic [CW-1:0] wr_ptr_reg, wr_ptr_next;
    logic          wr_overflow_reg, wr_overflow_next;
    logic          wr_en;
    logic [AW-1:0] wr_addr;

    // Read side state
    r_state_t      r_state_reg, r_state_next;
    logic [BW-1:0] rd_id_reg, rd_id_next;
    logic [CW-1:0] rd_len_reg, rd_len_next;
    logic [CW-1:0] rd_idx_reg, rd_idx_next;
    logic          rd_valid_reg, rd_valid_next;
    logic          rd_last_reg, rd_last_next;
    logic          rd_done_reg, rd_done_next;
    logic          rd_err_reg, rd_err_next;
    logic          rd_load;
    logic [BW-1:0] rd_load_id;
    logic [CW-1:0] rd_load_idx;
    logic [AW-1:0] rd_addr;
    logic          rd_pad_zero;
    logic [CW-1:0] rd_sel_count;
    logic [CW-1:0] rd_len_req;
    logic [CW:0]   rd_idx_plus2;
    logic [31:0]   rd_id_ext;
    logic          rd_reject;

    // Element-level ports map onto packed tiles for storage.
    for (genvar gi = 0; gi < ELEM; gi++) begin : g_pack
        assign tile_packed[gi*DATA_WIDTH +: DATA_WIDTH] = tile_data[gi];
        assign rd_data[gi] = rd_data_reg[gi*DATA_WIDTH +: DATA_WIDTH];
    end

    // ---------------- write path ----------------

    // Write FSM state and transaction registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_state_reg     <= W_IDLE;
            wr_id_reg       <= '0;
            wr_ptr_reg      <= '0;
            wr_overflow_reg <= 1'b0;
        end else begin
            w_state_reg     <= w_state_next;
            wr_id_reg       <= wr_id_next;
            wr_ptr_reg      <= wr_ptr_next;
            wr_overflow_reg <= wr_overflow_next;
        end
    end

    // Write FSM next state: open, fill (tile before done in the same cycle), commit.
    always_comb begin
        w_state_next     = w_state_reg;
        wr_id_next       = wr_id_reg;
        wr_ptr_next      = wr_ptr_reg;
        wr_overflow_next = wr_overflow_reg;
        wr_en            = 1'b0;
        case (w_state_reg)
            W_IDLE: begin
                if (wr_start) begin
                    wr_id_next       = wr_buf_id;
                    wr_ptr_next      = '0;
                    wr_overflow_next = 1'b0;
                    w_state_next     = W_FILL;
                end
            end
            W_FILL: begin
                if (tile_in) begin
                    if (wr_ptr_reg < CW'(MAX_TILES)) begin
                        wr_en       = 1'b1;
                        wr_ptr_next = wr_ptr_reg + CW'(1);
                    end else begin
                        wr_overflow_next = 1'b1;
                    end
                end
                if (load_done) begin
                    w_state_next = W_COMMIT;
                end
            end
            W_COMMIT: w_state_next = W_IDLE;
            default:  w_state_next = W_IDLE;
        endcase
    end

    assign wr_addr = AW'(wr_id_reg) * AW'(MAX_TILES) + AW'(wr_ptr_reg);

    // Tile store write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_reg[wr_addr] <= tile_packed;
        end
    end

    // Per-buffer tile counts, updated only on commit of that buffer.
    for (genvar gi = 0; gi < NUM_BUFS; gi++) begin : g_count
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                count_reg[gi] <= '0;
            end else if (w_state_reg == W_COMMIT && wr_id_reg == BW'(gi)) begin
                count_reg[gi] <= wr_ptr_reg;
            end
        end
    end

    assign wr_busy     = (w_state_reg != W_IDLE);
    assign wr_done     = (w_state_reg == W_COMMIT);
    assign wr_overflow = wr_overflow_reg;

    // ---------------- read path ----------------

    assign rd_id_ext    = 32'(rd_buf_id);
    assign rd_reject    = (wr_busy && rd_buf_id == wr_id_reg) || (rd_id_ext >= 32'(NUM_BUFS));
    assign rd_sel_count = count_reg[rd_buf_id];
    assign rd_idx_plus2 = {1'b0, rd_idx_reg} + (CW+1)'(2);

`ifdef VBUF_PAD_READ_EN
    logic [CW-1:0] rd_cnt_reg, rd_cnt_next;
    logic [CW-1:0] rd_load_cnt;

    assign rd_len_req = (rd_num_tiles > CW'(MAX_TILES)) ? CW'(MAX_TILES) : rd_num_tiles;
    // Count snapshot selects which indices read as zero padding.
    assign rd_load_cnt = (r_state_reg == R_IDLE) ? rd_sel_count : rd_cnt_reg;
    assign rd_cnt_next = (r_state_reg == R_IDLE && rd_load) ? rd_sel_count : rd_cnt_reg;
    assign rd_pad_zero = (rd_load_idx >= rd_load_cnt);

    // Stored count captured at stream start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_reg <= '0;
        end else begin
            rd_cnt_reg <= rd_cnt_next;
        end
    end
`else
    assign rd_len_req  = (rd_num_tiles < rd_sel_count) ? rd_num_tiles : rd_sel_count;
    assign rd_pad_zero = 1'b0;
`endif

    // Read FSM state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_reg  <= R_IDLE;
            rd_id_reg    <= '0;
            rd_len_reg   <= '0;
            rd_idx_reg   <= '0;
            rd_valid_reg <= 1'b0;
            rd_last_reg  <= 1'b0;
            rd_done_reg  <= 1'b0;
            rd_err_reg   <= 1'b0;
        end else begin
            r_state_reg  <= r_state_next;
            rd_id_reg    <= rd_id_next;
            rd_len_reg   <= rd_len_next;
            rd_idx_reg   <= rd_idx_next;
            rd_valid_reg <= rd_valid_next;
            rd_last_reg  <= rd_last_next;
            rd_done_reg  <= rd_done_next;
            rd_err_reg   <= rd_err_next;
        end
    end

    // Read FSM next state: accept/reject a request, then advance one tile per handshake.
    always_comb begin
        r_state_next  = r_state_reg;
        rd_id_next    = rd_id_reg;
        rd_len_next   = rd_len_reg;
        rd_idx_next   = rd_idx_reg;
        rd_valid_next = rd_valid_reg;
        rd_last_next  = rd_last_reg;
        rd_done_next  = 1'b0;
        rd_err_next   = 1'b0;
        rd_load       = 1'b0;
        rd_load_id    = rd_id_reg;
        rd_load_idx   = rd_idx_reg;
        case (r_state_reg)
            R_IDLE: begin
                if (rd_start) begin
                    if (rd_reject) begin
                        rd_err_next = 1'b1;
                    end else if (rd_len_req == '0) begin
                        rd_done_next = 1'b1;
                    end else begin
                        r_state_next  = R_STREAM;
                        rd_id_next    = rd_buf_id;
                        rd_len_next   = rd_len_req;
                        rd_idx_next   = '0;
                        rd_valid_next = 1'b1;
                        rd_last_next  = (rd_len_req == CW'(1));
                        rd_load       = 1'b1;
                        rd_load_id    = rd_buf_id;
                        rd_load_idx   = '0;
                    end
                end
            end
            R_STREAM: begin
                if (rd_valid_reg && rd_ready) begin
                    if (rd_last_reg) begin
                        rd_valid_next = 1'b0;
                        rd_last_next  = 1'b0;
                        rd_done_next  = 1'b1;
                        r_state_next  = R_IDLE;
                    end else begin
                        rd_idx_next  = rd_idx_reg + CW'(1);
                        rd_load      = 1'b1;
                        rd_load_idx  = rd_idx_reg + CW'(1);
                        rd_last_next = (rd_idx_plus2 == {1'b0, rd_len_reg});
                    end
                end
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    assign rd_addr = AW'(rd_load_id) * AW'(MAX_TILES) + AW'(rd_load_idx);

    // Registered read port; the output tile only changes on a load, so it holds during stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_reg <= '0;
        end else if (rd_load) begin
            rd_data_reg <= rd_pad_zero ? '0 : mem_reg[rd_addr];
        end
    end

    assign rd_valid = rd_valid_reg;
    assign rd_last  = rd_last_reg;
    assign rd_busy  = (r_state_reg == R_STREAM);
    assign rd_done  = rd_done_reg;
    assign rd_err   = rd_err_reg;

endmodule

// File: tb/tb_vector_tile_buffer.sv
// Testbench for vector_tile_buffer: directed write/read steps with a
// scoreboard queue of expected output tiles checked by a stream monitor.
module tb_vector_tile_buffer;

    localparam int ELEM = 32;
    localparam int MAXT = 32;

    typedef struct packed {
        logic [255:0] data;
        logic         last;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       wr_start;
    logic [1:0] wr_buf_id;
    logic       tile_in;
    logic [7:0] tile_data [ELEM];
    logic       load_done;
    logic       wr_busy, wr_done, wr_overflow;
    logic       rd_start;
    logic [1:0] rd_buf_id;
    logic [5:0] rd_num_tiles;
    logic [7:0] rd_data [ELEM];
    logic       rd_valid, rd_ready, rd_last, rd_busy, rd_done, rd_err;

    int n_vec  = 0;
    int n_miss = 0;

    exp_t         exp_q[$];
    logic [255:0] model_mem [4][MAXT];
    int           model_cnt [4];

    vector_tile_buffer dut (
        .clk(clk), .rst(rst),
        .wr_start(wr_start), .wr_buf_id(wr_buf_id), .tile_in(tile_in),
        .tile_data(tile_data), .load_done(load_done),
        .wr_busy(wr_busy), .wr_done(wr_done), .wr_overflow(wr_overflow),
        .rd_start(rd_start), .rd_buf_id(rd_buf_id), .rd_num_tiles(rd_num_tiles),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
        .rd_last(rd_last), .rd_busy(rd_busy), .rd_done(rd_done), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] gen_tile(input int seed, input int k);
        logic [255:0] t;
        for (int i = 0; i < ELEM; i++) t[i*8 +: 8] = 8'(seed + 16*k + i);
        return t;
    endfunction

    function automatic logic [255:0] pack_tile(input logic [7:0] t [ELEM]);
        logic [255:0] p;
        for (int i = 0; i < ELEM; i++) p[i*8 +: 8] = t[i];
        return p;
    endfunction

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stream monitor: every valid cycle must show the scoreboard head; a handshake retires it.
    always @(negedge clk) begin
        if (!rst && rd_valid) begin
            if (exp_q.size() == 0) begin
                chk("rd_unexpected_valid", rd_valid, 1'b0);
            end else begin
                chk("rd_data", pack_tile(rd_data), exp_q[0].data);
                chk("rd_last", rd_last, exp_q[0].last);
                if (rd_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic wr_open(input int id);
        wr_start  = 1'b1;
        wr_buf_id = 2'(id);
        tick();
        wr_start = 1'b0;
        chk("wr_busy_open", wr_busy, 1'b1);
        chk("wr_overflow_cleared", wr_overflow, 1'b0);
    endtask

    task automatic wr_fill(input int id, input int ntiles, input int seed, input bit coincide);
        logic [255:0] t;
        for (int k = 0; k < ntiles; k++) begin
            t = gen_tile(seed, k);
            for (int i = 0; i < ELEM; i++) tile_data[i] = t[i*8 +: 8];
            if (k < MAXT) model_mem[id][k] = t;
            tile_in = 1'b1;
            if (coincide && k == ntiles - 1) load_done = 1'b1;
            tick();
            tile_in   = 1'b0;
            load_done = 1'b0;
        end
        if (!coincide || ntiles == 0) begin
            load_done = 1'b1;
            tick();
            load_done = 1'b0;
        end
        chk("wr_done_pulse", wr_done, 1'b1);
        tick();
        chk("wr_done_clear", wr_done, 1'b0);
        chk("wr_busy_idle", wr_busy, 1'b0);
        model_cnt[id] = (ntiles < MAXT) ? ntiles : MAXT;
        $display("write buf=%0d tiles=%0d count=%0d overflow=%0b", id, ntiles, model_cnt[id], wr_overflow);
    endtask

    task automatic read_buf(input int id, input int num, input bit stall, input bit exp_err);
        int  n;
        int  cnt;
        bit  hs_last;
        bit  done_seen;
        cnt = model_cnt[id];
`ifdef VBUF_PAD_READ_EN
        n = (num > MAXT) ? MAXT : num;
`else
        n = (num < cnt) ? num : cnt;
`endif
        if (!exp_err) begin
            for (int k = 0; k < n; k++)
                exp_q.push_back('{data: (k < cnt) ? model_mem[id][k] : 256'd0, last: (k == n - 1)});
        end
        rd_start     = 1'b1;
        rd_buf_id    = 2'(id);
        rd_num_tiles = 6'(num);
        rd_ready     = 1'b1;
        tick();
        rd_start = 1'b0;
        if (exp_err) begin
            chk("rd_err_pulse", rd_err, 1'b1);
            chk("rd_err_no_valid", rd_valid, 1'b0);
            tick();
            chk("rd_err_clear", rd_err, 1'b0);
            chk("rd_err_still_idle", rd_valid, 1'b0);
            $display("read buf=%0d req=%0d rejected", id, num);
            return;
        end
        chk("rd_err_quiet", rd_err, 1'b0);
        chk("rd_first_valid", rd_valid, (n > 0));
        done_seen = 1'b0;
        if (n == 0) begin
            chk("rd_done_empty", rd_done, 1'b1);
            chk("rd_busy_empty", rd_busy, 1'b0);
            done_seen = 1'b1;
        end else begin
            for (int cyc = 0; cyc < 300; cyc++) begin
                hs_last = rd_valid && rd_ready && rd_last;
                tick();
                if (hs_last) begin
                    chk("rd_done_after_last", rd_done, 1'b1);
                    chk("rd_valid_after_last", rd_valid, 1'b0);
                    done_seen = 1'b1;
                    break;
                end
                rd_ready = stall ? (((cyc + 1) % 3) == 0) : 1'b1;
            end
        end
        chk("rd_done_seen", done_seen, 1'b1);
        chk("rd_queue_drained", exp_q.size(), 0);
        exp_q.delete();
        rd_ready = 1'b1;
        tick();
        chk("rd_done_clear", rd_done, 1'b0);
        chk("rd_busy_clear", rd_busy, 1'b0);
        $display("read buf=%0d req=%0d tiles=%0d stall=%0b", id, num, n, stall);
    endtask

    initial begin
        rst = 1'b1;
        wr_start = 1'b0; wr_buf_id = '0; tile_in = 1'b0; load_done = 1'b0;
        rd_start = 1'b0; rd_buf_id = '0; rd_num_tiles = '0; rd_ready = 1'b0;
        for (int i = 0; i < ELEM; i++) tile_data[i] = '0;
        for (int b = 0; b < 4; b++) model_cnt[b] = 0;

        // Reset state
        tick(); tick();
        chk("reset_rd_valid", rd_valid, 1'b0);
        chk("reset_rd_data", pack_tile(rd_data), 256'd0);
        rst = 1'b0;
        tick();
        chk("reset_wr_busy", wr_busy, 1'b0);
        chk("reset_outputs", {wr_done, wr_overflow, rd_last, rd_busy, rd_done, rd_err}, 6'd0);

        // Three tiles into buffer 2, load_done on the last tile; straight and stalled reads
        wr_open(2);
        wr_fill(2, 3, 0, 1'b1);
        read_buf(2, 3, 1'b0, 1'b0);
        read_buf(2, 3, 1'b1, 1'b0);

        // Never-written buffer: count 0
        read_buf(0, 4, 1'b0, 1'b0);

        // Overflow: 33 tiles into 32 slots
        wr_open(3);
        wr_fill(3, 33, 8'h40, 1'b0);
        chk("overflow_set", wr_overflow, 1'b1);
        read_buf(3, 33, 1'b0, 1'b0);
        wr_open(3);
        wr_fill(3, 0, 0, 1'b0);

        // Read collision with an open write, and a concurrent read of another buffer
        wr_open(1);
        read_buf(1, 2, 1'b0, 1'b1);
        read_buf(2, 3, 1'b0, 1'b0);
        wr_fill(1, 2, 8'h20, 1'b1);
        read_buf(1, 5, 1'b0, 1'b0);
        read_buf(1, 1, 1'b1, 1'b0);

        // Reset mid-stream and mid-fill
        for (int k = 0; k < 3; k++)
            exp_q.push_back('{data: model_mem[2][k], last: (k == 2)});
        rd_start = 1'b1; rd_buf_id = 2'd2; rd_num_tiles = 6'd3; rd_ready = 1'b0;
        tick();
        rd_start = 1'b0;
        chk("prereset_valid", rd_valid, 1'b1);
        wr_open(0);
        tile_in = 1'b1;
        tick();
        tile_in = 1'b0;
        rst = 1'b1;
        tick();
        chk("midreset_rd_valid", rd_valid, 1'b0);
        chk("midreset_wr_busy", wr_busy, 1'b0);
        chk("midreset_rd_busy", rd_busy, 1'b0);
        chk("midreset_rd_data", pack_tile(rd_data), 256'd0);
        exp_q.delete();
        for (int b = 0; b < 4; b++) model_cnt[b] = 0;
        rst = 1'b0;
        rd_ready = 1'b1;
        tick();
        chk("postreset_wr_done", wr_done, 1'b0);
        read_buf(2, 3, 1'b0, 1'b0);
        read_buf(1, 2, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
